// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings for the manager, the USB satellite and their benches.
package ahb_lite_pkg;

   localparam int unsigned HDATA_W = 32;
   localparam int unsigned CDATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_HALF = 1'b1;

   typedef enum logic {
      RUN     = 1'b0,
      BACKOFF = 1'b1
   } mgr_state_t;

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte/halfword lane handling: write replication across hwdata and read extraction from hrdata.
module ahb_lane_steer
   import ahb_lite_pkg::*;
(
   input  logic               w_size,
   input  logic [CDATA_W-1:0] wdata,
   input  logic               r_size,
   input  logic [1:0]         r_addr,
   input  logic [HDATA_W-1:0] hrdata,
   output logic [HDATA_W-1:0] hwdata_c,
   output logic [CDATA_W-1:0] rdata_c
);

   always_comb begin
      hwdata_c = {4{wdata[7:0]}};
      rdata_c  = {8'h00, hrdata[{r_addr, 3'b000} +: 8]};
      if (w_size == SIZE_HALF) begin
         hwdata_c = {2{wdata}};
      end
      if (r_size == SIZE_HALF) begin
         rdata_c = hrdata[{r_addr[1], 4'b0000} +: 16];
      end
   end

endmodule

// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: accept -> address phase -> data phase pipeline, one in-order response per command.
module ahb_lite_manager
   import ahb_lite_pkg::*;
#(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned ERR_BACKOFF = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_write,
   input  logic [ADDR_W-1:0]  cmd_addr,
   input  logic               cmd_size,
   input  logic [CDATA_W-1:0] cmd_wdata,
   output logic               rsp_valid,
   output logic [CDATA_W-1:0] rsp_rdata,
   output logic               rsp_error,
   output logic               hsel,
   output logic               hwrite,
   output logic               hsize,
   output logic [1:0]         htrans,
   output logic [ADDR_W-1:0]  haddr,
   output logic [HDATA_W-1:0] hwdata,
   input  logic [HDATA_W-1:0] hrdata,
   input  logic               hresp
);

   localparam int unsigned CNT_W = 2;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ERR_BACKOFF - 1);

   mgr_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               hsel_q, hsel_d;
   htrans_t            htrans_q, htrans_d;
   logic [ADDR_W-1:0]  haddr_q, haddr_d;
   logic               hsize_q, hsize_d;
   logic               hwrite_q, hwrite_d;
   logic [CDATA_W-1:0] ap_wdata_q, ap_wdata_d;
   logic               ap_abort_q, ap_abort_d;

   logic               dp_real_q, dp_real_d;
   logic               dp_abort_q, dp_abort_d;
   logic               dp_write_q, dp_write_d;
   logic               dp_size_q, dp_size_d;
   logic [1:0]         dp_addr_q, dp_addr_d;
   logic [HDATA_W-1:0] hwdata_q, hwdata_d;

   logic               rsp_valid_q, rsp_valid_d;
   logic [CDATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic               rsp_error_q, rsp_error_d;

   logic               accept_c;
   logic               misaligned_c;
   logic               bus_err_c;
   logic               ap_go_c;
   logic [HDATA_W-1:0] wr_lanes_c;
   logic [CDATA_W-1:0] rd_lane_c;

   assign cmd_ready    = ~rst & (state_q == RUN);
   assign accept_c     = cmd_valid & cmd_ready;
   assign misaligned_c = (cmd_size == SIZE_HALF) & cmd_addr[0];
   assign bus_err_c    = dp_real_q & hresp;

   ahb_lane_steer u_steer (
      .w_size   (hsize_q),
      .wdata    (ap_wdata_q),
      .r_size   (dp_size_q),
      .r_addr   (dp_addr_q),
      .hrdata   (hrdata),
      .hwdata_c (wr_lanes_c),
      .rdata_c  (rd_lane_c)
   );

   // Error backoff FSM; a further error while backing off restarts the count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (bus_err_c) begin
               state_d = BACKOFF;
               cnt_d   = CNT_LOAD;
            end
         end
         BACKOFF: begin
            if (bus_err_c) begin
               cnt_d = CNT_LOAD;
            end else if (cnt_q == '0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   // A command accepted on the edge that enters BACKOFF is aborted like a misaligned one.
   always_comb begin
      ap_go_c     = accept_c & ~misaligned_c & (state_d == RUN);
      hsel_d      = ap_go_c;
      htrans_d    = ap_go_c ? NONSEQ : IDLE;
      haddr_d     = ap_go_c ? cmd_addr : '0;
      hsize_d     = ap_go_c & cmd_size;
      hwrite_d    = ap_go_c & cmd_write;
      ap_wdata_d  = (ap_go_c & cmd_write) ? cmd_wdata : '0;
      ap_abort_d  = accept_c & ~ap_go_c;

      dp_real_d   = hsel_q;
      dp_abort_d  = ap_abort_q;
      dp_write_d  = hwrite_q;
      dp_size_d   = hsize_q;
      dp_addr_d   = haddr_q[1:0];
      hwdata_d    = (hsel_q & hwrite_q) ? wr_lanes_c : '0;

      rsp_valid_d = dp_real_q | dp_abort_q;
      rsp_error_d = dp_abort_q | bus_err_c;
      rsp_rdata_d = (dp_real_q & ~dp_write_q & ~hresp) ? rd_lane_c : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         hsel_q      <= 1'b0;
         htrans_q    <= IDLE;
         haddr_q     <= '0;
         hsize_q     <= 1'b0;
         hwrite_q    <= 1'b0;
         ap_wdata_q  <= '0;
         ap_abort_q  <= 1'b0;
         dp_real_q   <= 1'b0;
         dp_abort_q  <= 1'b0;
         dp_write_q  <= 1'b0;
         dp_size_q   <= 1'b0;
         dp_addr_q   <= '0;
         hwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hsel_q      <= hsel_d;
         htrans_q    <= htrans_d;
         haddr_q     <= haddr_d;
         hsize_q     <= hsize_d;
         hwrite_q    <= hwrite_d;
         ap_wdata_q  <= ap_wdata_d;
         ap_abort_q  <= ap_abort_d;
         dp_real_q   <= dp_real_d;
         dp_abort_q  <= dp_abort_d;
         dp_write_q  <= dp_write_d;
         dp_size_q   <= dp_size_d;
         dp_addr_q   <= dp_addr_d;
         hwdata_q    <= hwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign hsel      = hsel_q;
   assign htrans    = htrans_q;
   assign haddr     = haddr_q;
   assign hsize     = hsize_q;
   assign hwrite    = hwrite_q;
   assign hwdata    = hwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Scoreboard bench for ahb_lite_manager: directed commands push expected responses, a monitor pops them.
module tb_ahb_lite_manager;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [3:0]  cmd_addr;
   logic        cmd_size;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_error;
   logic        hsel, hwrite, hsize;
   logic [1:0]  htrans;
   logic [3:0]  haddr;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hresp;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   ahb_lite_manager #(.ADDR_W(4), .ERR_BACKOFF(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_size  (cmd_size),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .hsel      (hsel),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .htrans    (htrans),
      .haddr     (haddr),
      .hwdata    (hwdata),
      .hrdata    (hrdata),
      .hresp     (hresp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic idle();
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_size  = 1'b0;
      cmd_wdata = '0;
   endtask

   // Called at a negedge; the command is accepted at the following posedge.
   task automatic drive(input logic wr, input logic [3:0] addr, input logic sz,
                        input logic [15:0] wd, input logic [15:0] erd, input logic eerr);
      int n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_size  = sz;
      cmd_wdata = wd;
      sb.push_back('{rdata: erd, err: eerr, cyc: cyc + 3});
   endtask

   task automatic half_write_test();
      drive(1'b1, 4'd4, 1'b1, 16'hBEEF, 16'h0000, 1'b0);
      @(negedge clk);
      idle();
      chk("hw_hsel", 32'(hsel), 32'd1);
      chk("hw_htrans", 32'(htrans), 32'd2);
      chk("hw_haddr", 32'(haddr), 32'd4);
      chk("hw_hsize", 32'(hsize), 32'd1);
      chk("hw_hwrite", 32'(hwrite), 32'd1);
      @(negedge clk);
      chk("hw_hwdata", hwdata, 32'hBEEFBEEF);
      chk("hw_htrans_idle", 32'(htrans), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // Response monitor: every rsp_valid must match the oldest expectation, on its cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected actual rdata=%h err=%b required no response at cycle %0d",
                        rsp_rdata, rsp_error, cyc);
            end else begin
               e = sb.pop_front();
               if (rsp_rdata !== e.rdata || rsp_error !== e.err || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL rsp actual rdata=%h err=%b cycle=%0d required rdata=%h err=%b cycle=%0d",
                           rsp_rdata, rsp_error, cyc, e.rdata, e.err, e.cyc);
               end
            end
         end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            checks++;
            errors++;
            e = sb.pop_front();
            $display("FAIL rsp_missing actual none required rdata=%h err=%b at cycle %0d",
                     e.rdata, e.err, e.cyc);
         end
      end
   end

   initial begin
      rst    = 1'b1;
      hrdata = '0;
      hresp  = 1'b0;
      idle();
      repeat (3) @(negedge clk);

      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_hsel", 32'(hsel), 32'd0);
      chk("rst_htrans", 32'(htrans), 32'd0);
      chk("rst_haddr", 32'(haddr), 32'd0);
      chk("rst_hwdata", hwdata, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

      half_write_test();

      // Back-to-back byte write then byte read from lane 3
      drive(1'b1, 4'd0, 1'b0, 16'h005A, 16'h0000, 1'b0);
      @(negedge clk);
      drive(1'b0, 4'd3, 1'b0, 16'h0000, 16'h00A5, 1'b0);
      chk("b2b_w_hwrite", 32'(hwrite), 32'd1);
      chk("b2b_w_hsize", 32'(hsize), 32'd0);
      @(negedge clk);
      idle();
      chk("b2b_hwdata", hwdata, 32'h5A5A5A5A);
      chk("b2b_r_haddr", 32'(haddr), 32'd3);
      chk("b2b_r_hwrite", 32'(hwrite), 32'd0);
      @(negedge clk);
      hrdata = 32'hA500_0000;
      chk("b2b_r_hwdata_zero", hwdata, 32'd0);
      @(negedge clk);
      hrdata = '0;
      repeat (2) @(negedge clk);

      // Misaligned halfword read; stray hresp in its empty slot must be ignored
      drive(1'b0, 4'd1, 1'b1, 16'h0000, 16'h0000, 1'b1);
      @(negedge clk);
      idle();
      chk("mis_htrans", 32'(htrans), 32'd0);
      chk("mis_hsel", 32'(hsel), 32'd0);
      @(negedge clk);
      hrdata = 32'hFFFF_FFFF;
      hresp  = 1'b1;
      @(negedge clk);
      hrdata = '0;
      hresp  = 1'b0;
      chk("mis_no_backoff", 32'(cmd_ready), 32'd1);
      repeat (2) @(negedge clk);

      // Bus error on write, pipelined read still completes; one backoff cycle
      drive(1'b1, 4'hC, 1'b0, 16'h0011, 16'h0000, 1'b1);
      @(negedge clk);
      drive(1'b0, 4'h8, 1'b1, 16'h0000, 16'h5678, 1'b0);
      @(negedge clk);
      idle();
      hresp = 1'b1;
      chk("err_ready_before", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      hresp  = 1'b0;
      hrdata = 32'h1234_5678;
      chk("err_backoff_ready", 32'(cmd_ready), 32'd0);
      chk("err_backoff_htrans", 32'(htrans), 32'd0);
      @(negedge clk);
      hrdata = '0;
      chk("err_ready_after", 32'(cmd_ready), 32'd1);
      repeat (2) @(negedge clk);

      // Reset with a read in data phase and a write in address phase
      drive(1'b0, 4'd6, 1'b1, 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      drive(1'b1, 4'd2, 1'b0, 16'h0077, 16'h0000, 1'b0);
      @(negedge clk);
      idle();
      hrdata = 32'hDEAD_0000;
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("mid_rst_hsel", 32'(hsel), 32'd0);
      chk("mid_rst_htrans", 32'(htrans), 32'd0);
      chk("mid_rst_haddr", 32'(haddr), 32'd0);
      chk("mid_rst_hwrite", 32'(hwrite), 32'd0);
      chk("mid_rst_hwdata", hwdata, 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (3) @(negedge clk);
      hrdata = '0;
      rst    = 1'b0;
      @(negedge clk);
      chk("rerelease_cmd_ready", 32'(cmd_ready), 32'd1);

      half_write_test();

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_lite_manager.md
# ahb_lite_manager

AHB-Lite manager (initiator) that turns simple command requests into pipelined AHB-Lite transfers toward the USB AHB-Lite satellite's register file. It sits between firmware-side or test-harness command logic and the satellite's bus port. It drives the address and data phases, steers byte and halfword data lanes, and returns one response per accepted command, in order.

## Interface
Parameters:
- ADDR_W, 4, satellite address width.
- ERR_BACKOFF, 1, IDLE cycles forced after an error response (1..3).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_size  in  1  0 = byte, 1 = halfword.
- cmd_wdata  in  16  write data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  16  read data, zero-extended; 0 for writes.
- rsp_error  out  1  bus error or misaligned command.
- hsel, hwrite, hsize  out  1 each  AHB-Lite control.
- htrans  out  2  IDLE = 00, NONSEQ = 10 only.
- haddr  out  ADDR_W  transfer address.
- hwdata  out  32  write data during data phase.
- hrdata  in  32  read data, sampled at end of data phase.
- hresp  in  1  error, sampled at end of data phase.

## Operation
- Three-stage pipeline: accept → address phase → data phase. The subordinate has no wait states and no hready.
- Address phase, valid command: hsel = 1, htrans = NONSEQ, haddr/hsize/hwrite registered from the command.
- Address phase, no command: hsel = 0, htrans = IDLE, haddr/hsize/hwrite = 0.
- Write lane steering:
  - Byte: hwdata = wdata[7:0] replicated on all 4 lanes.
  - Halfword: hwdata = wdata[15:0] replicated on both halves.
  - hwdata = 0 in any cycle that is not a write data phase.
- Read extraction:
  - Byte: hrdata[8*addr[1:0] +: 8].
  - Halfword: hrdata[16*addr[1] +: 16].
- Misaligned command (cmd_size = 1, addr[0] = 1):
  - Accepted normally.
  - Its address-phase slot drives IDLE; no bus transfer occurs.
  - Response arrives with rsp_error = 1, rsp_rdata = 0, at normal latency, so ordering is preserved.
- FSM states:
  - RUN: cmd_ready = 1.
  - BACKOFF: cmd_ready = 0, htrans forced IDLE, counter counts ERR_BACKOFF cycles, then returns to RUN.
- RUN → BACKOFF: at the edge where hresp = 1 is sampled for a real transfer.
- A transfer already in its address phase when hresp is sampled was captured by the subordinate. It completes normally and gets its own response.
- hresp sampled while BACKOFF is already active restarts the counter.
- hresp outside a valid data phase is ignored.

## Timing
- Accept at edge E0:
  - Address phase: E0–E1.
  - Data phase: E1–E2; hrdata/hresp sampled at E2.
  - rsp_valid high E2–E3.
- Total: 3 cycles from accept to response.
- Throughput: one command per cycle in RUN. Address phase of N+1 overlaps data phase of N.
- cmd_ready is combinational from state only, with no dependency on cmd_valid.
- Reset values: all outputs 0 (cmd_ready = 0 while rst = 1); FSM in RUN; pipeline empty. Outputs clear asynchronously on rst assertion.
- Reset mid-transfer: in-flight commands are discarded with no response. The first accept is possible in the first cycle after rst deasserts.

## Structure
- Package ahb_lite_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ).
  - hsize encodings (SIZE_BYTE = 0, SIZE_HALF = 1).
  - mgr_state_t (RUN, BACKOFF).
- The satellite RTL and bench import the same package.
- One sub-module, ahb_lane_steer: combinational write replication and read extraction, keyed by size and addr[1:0]. The FSM and pipeline registers stay in ahb_lite_manager.

## Test plan
- Reset and release:
  - Assert rst mid-cycle → all h* outputs, cmd_ready and rsp_valid go 0 immediately.
  - Deassert → cmd_ready = 1 next cycle.
- Halfword write, addr 4, data 0xBEEF:
  - Address phase: hsel = 1, htrans = 10, haddr = 4, hsize = 1, hwrite = 1.
  - Data phase: hwdata = 0xBEEFBEEF.
  - Next cycle: rsp_valid = 1, rsp_error = 0, rsp_rdata = 0.
- Back-to-back: byte write addr 0 (0x5A), then byte read addr 3, with hrdata = 0xA5000000 in the read data phase:
  - The read's address phase coincides with hwdata = 0x5A5A5A5A.
  - Responses on consecutive cycles; read rsp_rdata = 0x00A5.
- Misaligned halfword read at addr 1:
  - Its slot shows htrans = 00, hsel = 0.
  - rsp_valid with rsp_error = 1, rsp_rdata = 0, 3 cycles after accept.
- Error: write addr 0xC, then pipelined read addr 8, hresp = 1 during the write's data phase (ERR_BACKOFF = 1):
  - Write response rsp_error = 1.
  - Read completes with rsp_error = 0.
  - Exactly one cycle with cmd_ready = 0 and htrans = 00.
- rst asserted during a read's data phase → no rsp_valid for it; the first command after release behaves as in the halfword-write test.
